// File: rtl/pwm_dither_dac.sv
// pwm_dither_dac: multi-channel PWM DAC with frame-synchronous shadow-to-active code transfer.
// Define PWM_DITHER_EN to spread the fine code bits over a frame in bit-reversed period order.
module pwm_dither_dac #(
  parameter int NCH = 4,
  parameter int IN_W = 12,
  parameter int DB = 4,
  parameter int PERIOD = 156
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH*IN_W-1:0]   in_dat,
  input  logic [NCH-1:0]        in_we,
  output logic [NCH-1:0]        pwm_o,
  output logic                  frame_o,
  output logic [NCH-1:0]        busy_o
);
  localparam int CW = ((IN_W - DB) > 8 ? IN_W - DB : 8) + 1;
  localparam logic [CW-1:0] PMAX = CW'(PERIOD);
  logic [7:0] cnt;
  logic [DB-1:0] pix;
  logic wrap, last;
  assign wrap = cnt == 8'(PERIOD - 1);
  assign last = wrap && &pix;
`ifdef PWM_DITHER_EN
  logic [DB-1:0] rev;
  always_comb
    for (int b = 0; b < DB; b++) rev[b] = pix[DB-1-b];
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= 8'd0;
      pix <= '0;
      frame_o <= 1'b0;
    end else begin
      cnt <= wrap ? 8'd0 : cnt + 8'd1;
      pix <= wrap ? pix + DB'(1) : pix;
      frame_o <= last;
    end
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [IN_W-1:0] shadow, act;
    logic [CW-1:0] sum, cmp;
    logic pwm_q, busy_q;
`ifdef PWM_DITHER_EN
    assign sum = CW'(act >> DB) + CW'(rev < act[DB-1:0]);
`else
    assign sum = CW'(act >> DB);
`endif
    assign cmp = sum > PMAX ? PMAX : sum;
    assign pwm_o[c] = pwm_q;
    assign busy_o[c] = busy_q;
    // a write landing on the transfer clock bypasses the shadow entirely
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        shadow <= '0;
        act <= '0;
        busy_q <= 1'b0;
        pwm_q <= 1'b0;
      end else begin
        pwm_q <= CW'(cnt) < cmp;
        if (in_we[c]) shadow <= in_dat[c*IN_W +: IN_W];
        if (last) act <= in_we[c] ? in_dat[c*IN_W +: IN_W] : busy_q ? shadow : act;
        busy_q <= in_we[c] ? !last : busy_q && !last;
      end
  end
endmodule

// File: tb/tb_pwm_dither_dac.sv
// tb_pwm_dither_dac: directed bench with a frame-level reference model checked every clock.
module tb_pwm_dither_dac;
  localparam int NCH = 2, IN_W = 12, DB = 4, P = 156, FR = P * (1 << DB);
`ifdef PWM_DITHER_EN
  localparam int DITH = 1;
`else
  localparam int DITH = 0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic [NCH*IN_W-1:0] in_dat = '0;
  logic [NCH-1:0] in_we = '0, pwm_o, busy_o;
  logic frame_o;
  int errs = 0, checks = 0;
  bit armed = 0;
  always #5 clk = ~clk;

  pwm_dither_dac #(.NCH(NCH), .IN_W(IN_W), .DB(DB), .PERIOD(P)) dut (
    .clk(clk), .rst(rst), .in_dat(in_dat), .in_we(in_we),
    .pwm_o(pwm_o), .frame_o(frame_o), .busy_o(busy_o)
  );

  // high time in clocks of one PWM period at period index p for a given code
  function automatic int width_of(int code, int p);
    int w = code >> DB;
    int r = 0;
    int inc = 0;
    for (int b = 0; b < DB; b++) if (((p >> b) & 1) == 1) r |= 1 << (DB - 1 - b);
`ifdef PWM_DITHER_EN
    inc = r < (code % (1 << DB)) ? 1 : 0;
`endif
    w += inc;
    return w > P ? P : w;
  endfunction

  // model: time since reset release drives position; codes follow frame-boundary transfer rules
  int t;
  int m_act [NCH];
  int m_sh [NCH];
  logic [NCH-1:0] e_pwm, e_busy;
  logic e_frame, m_last;
  assign m_last = (t % FR) == FR - 1;
  always @(posedge clk or negedge rst)
    if (!rst) begin
      t <= 0;
      e_pwm <= '0;
      e_busy <= '0;
      e_frame <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_act[i] <= 0;
        m_sh[i] <= 0;
      end
    end else begin
      t <= t + 1;
      e_frame <= m_last;
      for (int i = 0; i < NCH; i++) begin
        e_pwm[i] <= (t % P) < width_of(m_act[i], (t / P) % (1 << DB));
        if (in_we[i]) begin
          if (m_last) m_act[i] <= int'(in_dat[i*IN_W +: IN_W]);
          else m_sh[i] <= int'(in_dat[i*IN_W +: IN_W]);
          e_busy[i] <= !m_last;
        end else if (m_last) begin
          if (e_busy[i]) m_act[i] <= m_sh[i];
          e_busy[i] <= 1'b0;
        end
      end
    end

  always @(negedge clk)
    if (armed) begin
      checks++;
      if ({pwm_o, busy_o, frame_o} !== {e_pwm, e_busy, e_frame}) begin
        errs++;
        if (errs < 20)
          $display("FAIL model t=%0d: got pwm=%b busy=%b frame=%b, want pwm=%b busy=%b frame=%b",
                   t, pwm_o, busy_o, frame_o, e_pwm, e_busy, e_frame);
      end
    end

  // per-frame high-clock totals; the pwm sample on the frame_o clock closes the previous frame
  int acc [NCH];
  int frame_hi [NCH];
  always @(negedge clk)
    for (int i = 0; i < NCH; i++)
      if (!rst) acc[i] <= 0;
      else if (frame_o) begin
        frame_hi[i] <= acc[i] + int'(pwm_o[i]);
        acc[i] <= 0;
      end else acc[i] <= acc[i] + int'(pwm_o[i]);

  task automatic chk(string name, int got, int want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(int ch, int val);
    in_dat[ch*IN_W +: IN_W] = IN_W'(val);
    in_we[ch] = 1'b1;
    tick;
    in_we = '0;
  endtask

  task automatic wait_frame;
    for (int n = 0; n < FR + 500; n++) begin
      tick;
      if (frame_o) return;
    end
    chk("frame_timeout", 0, 1);
  endtask

  initial begin
    repeat (2) tick;
    armed = 1;
    chk("reset_pwm", int'(pwm_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_frame", int'(frame_o), 0);
    chk("pin_503_pix0", width_of('h503, 0), 80 + DITH);
    chk("pin_503_pix8", width_of('h503, 8), 80 + DITH);
    chk("pin_503_pix4", width_of('h503, 4), 80 + DITH);
    chk("pin_503_pix12", width_of('h503, 12), 80);
    chk("pin_ff0_sat", width_of('hFF0, 0), 156);
    rst = 1'b1;
    wr(0, 'h000);
    wr(1, 'h503);
    chk("busy_after_write", int'(busy_o), 3);
    wait_frame;
    chk("busy_after_transfer", int'(busy_o), 0);
    wait_frame;
    #5;
    chk("frame_hi_000", frame_hi[0], 0);
    chk("frame_hi_503", frame_hi[1], 1280 + 3 * DITH);
    wr(0, 'h9C0);
    wait_frame;
    wait_frame;
    #5;
    chk("frame_hi_9c0", frame_hi[0], FR);
    chk("frame_hi_503_again", frame_hi[1], 1280 + 3 * DITH);
    wr(0, 'hFF0);
    wait_frame;
    wait_frame;
    #5;
    chk("frame_hi_ff0", frame_hi[0], FR);
    wr(1, 'h100);
    repeat (100) tick;
    wr(1, 'h200);
    chk("busy_pending", int'(busy_o[1]), 1);
    wait_frame;
    chk("busy_cleared", int'(busy_o[1]), 0);
    wait_frame;
    #5;
    chk("frame_hi_200", frame_hi[1], 512);
    repeat (FR - 1) tick;
    in_dat[IN_W +: IN_W] = IN_W'('h0A5);
    in_we[1] = 1'b1;
    tick;
    in_we = '0;
    chk("busy_on_transfer_write", int'(busy_o[1]), 0);
    chk("frame_after_transfer", int'(frame_o), 1);
    wait_frame;
    #5;
    chk("frame_hi_0a5", frame_hi[1], 160 + 5 * DITH);
    wr(0, 'h500);
    wr(1, 'h300);
    repeat (50) tick;
    rst = 1'b0;
    #2;
    chk("midreset_pwm", int'(pwm_o), 0);
    chk("midreset_busy", int'(busy_o), 0);
    chk("midreset_frame", int'(frame_o), 0);
    repeat (3) tick;
    rst = 1'b1;
    wait_frame;
    chk("busy_after_reset", int'(busy_o), 0);
    wait_frame;
    #5;
    chk("frame_hi_after_reset0", frame_hi[0], 0);
    chk("frame_hi_after_reset1", frame_hi[1], 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
